// File: rtl/mem_req_master_pkg.sv
// Shared widths, FSM encoding and request record for the single-bank request master.
package mem_req_master_pkg;

    localparam int BANK_ADDR_WIDTH  = 4;
    localparam int COL_ADDR_WIDTH   = 2;
    localparam int TX_DATA_WIDTH    = 8;
    localparam int GRID_VEC_ALIGN_N = 40;
    localparam int MEM_REQ_TIMEOUT  = 16;

    localparam logic [1:0] MRQ_IDLE  = 2'd0;
    localparam logic [1:0] MRQ_ISSUE = 2'd1;
    localparam logic [1:0] MRQ_RESP  = 2'd2;

    typedef struct packed {
        logic                       write;
        logic                       pad;
        logic [BANK_ADDR_WIDTH-1:0] row;
        logic [COL_ADDR_WIDTH-1:0]  col;
        logic [TX_DATA_WIDTH-1:0]   data;
    } mem_req_t;

    // Bit position of a slice column inside the aligned grid vector.
    function automatic int vec_offset(input logic [COL_ADDR_WIDTH-1:0] col);
        return int'(col) * TX_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/mem_req_master_if.sv
// Request/response stream between the grid scheduler (master) and one bank request master (slave).
interface mem_req_master_if;
    import mem_req_master_pkg::*;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic                       req_pad;
    logic [BANK_ADDR_WIDTH-1:0] req_row;
    logic [COL_ADDR_WIDTH-1:0]  req_col;
    logic [TX_DATA_WIDTH-1:0]   req_data;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_write;
    logic                       rsp_err;
    logic [TX_DATA_WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_write, req_pad, req_row, req_col, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_pad, req_row, req_col, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_err, rsp_data
    );

endinterface

// File: rtl/mem_req_master.sv
// Single-bank request master: accepts one slice request, holds the mem enables until ack
// or timeout, then presents the result on the response stream.
module mem_req_master
    import mem_req_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_REQ_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    mem_req_master_if.slave            bus,
    output logic                       timeout_err,
    output logic                       mem_read_en,
    output logic                       mem_write_en,
    output logic                       mem_pad_en,
    output logic [BANK_ADDR_WIDTH-1:0] mem_row_addr,
    output logic [COL_ADDR_WIDTH-1:0]  mem_col_addr,
    output logic [TX_DATA_WIDTH-1:0]   mem_partial_vec,
    input  logic                       mem_ack,
    input  logic                       mem_busy,
    input  logic [TX_DATA_WIDTH-1:0]   mem_rd_data
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]               state_q, state_d;
    mem_req_t                 req_q, req_d;
    logic [CNT_W-1:0]         tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
    logic                     rsp_err_q, rsp_err_d;
    logic [TX_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     in_issue, accept, tmo_hit;

    assign in_issue    = (state_q == MRQ_ISSUE);
    assign bus.req_ready = (state_q == MRQ_IDLE) || ((state_q == MRQ_RESP) && bus.rsp_ready);
    assign accept      = bus.req_valid && bus.req_ready;
    assign tmo_cnt_inc = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    // The current ISSUE cycle is the last one allowed when the incremented count hits the limit.
    assign tmo_hit     = (tmo_cnt_inc == CNT_MAX);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        tmo_cnt_d     = tmo_cnt_q;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        timeout_err_d = timeout_err_q;

        if (accept) begin
            req_d.write = bus.req_write;
            req_d.pad   = bus.req_pad;
            req_d.row   = bus.req_row;
            req_d.col   = bus.req_col;
            req_d.data  = bus.req_data;
            tmo_cnt_d   = '0;
            state_d     = MRQ_ISSUE;
        end

        case (state_q)
            MRQ_IDLE: ;
            MRQ_ISSUE: begin
                // An ack on the limit cycle takes priority over the timeout.
                if (mem_ack) begin
                    rsp_data_d = req_q.write ? '0 : mem_rd_data;
                    rsp_err_d  = 1'b0;
                    state_d    = MRQ_RESP;
                end else if (tmo_hit) begin
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = MRQ_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                end
            end
            MRQ_RESP: begin
                if (bus.rsp_ready && !accept) begin
                    state_d = MRQ_IDLE;
                end
            end
            default: state_d = MRQ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= MRQ_IDLE;
            req_q         <= '0;
            tmo_cnt_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Enables come only from the state, so they fall the cycle after ack and a write never re-commits.
    assign mem_read_en     = in_issue && !req_q.write;
    assign mem_write_en    = in_issue && req_q.write;
    assign mem_pad_en      = in_issue && req_q.write && req_q.pad;
    assign mem_row_addr    = req_q.row;
    assign mem_col_addr    = req_q.col;
    assign mem_partial_vec = req_q.data;

    assign bus.rsp_valid = (state_q == MRQ_RESP);
    assign bus.rsp_write = req_q.write;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign timeout_err   = timeout_err_q;

`ifndef SYNTHESIS
    ack_only_in_issue: assert property (@(posedge clock) disable iff (reset)
        mem_ack |-> in_issue);
    busy_while_enabled: assert property (@(posedge clock) disable iff (reset)
        (mem_read_en || mem_write_en) |-> mem_busy);
    slice_fits_vector: assert property (@(posedge clock) disable iff (reset)
        accept |-> (vec_offset(bus.req_col) + int'(bus.req_pad && bus.req_write)
                    + TX_DATA_WIDTH <= GRID_VEC_ALIGN_N));
`endif

endmodule
